// File: rtl/write_queue_arb.sv
// Round-robin arbiter that grants one wide producer word at a time and
// serializes it onto a shared narrow link, LSB slice first, with a source id.
module write_queue_arb #(
    parameter int NUM_PORTS = 4,
    parameter int IN_WIDTH  = 512,
    parameter int OUT_WIDTH = 32,
    parameter int ID_WIDTH  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_PORTS*IN_WIDTH-1:0] din,
    input  logic [NUM_PORTS-1:0]          vld_in,
    output logic [NUM_PORTS-1:0]          rdy_upward,
    output logic [OUT_WIDTH-1:0]          dout,
    output logic                          vld_out,
    output logic                          last_out,
    output logic [ID_WIDTH-1:0]           src_id,
    input  logic                          rdy_downward,
    input  logic                          ap_start
);
    localparam int MAX   = IN_WIDTH / OUT_WIDTH;
    localparam int CNT_W = $clog2(MAX);
    localparam int PTR_W = $clog2(NUM_PORTS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_PORTS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [PTR_W-1:0]    grant_q, grant_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IN_WIDTH-1:0] sreg_q, sreg_d;
    logic                ap_start_dly_q;

    logic [PTR_W-1:0]    winner;
    logic [IN_WIDTH-1:0] win_word;
    logic                any_vld, arb_ok, capture;

    // First valid port at or after ptr, wrapping modulo NUM_PORTS.
    always_comb begin
        int               idx;
        logic [PTR_W-1:0] cand;
        idx     = 0;
        cand    = '0;
        winner  = '0;
        any_vld = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
            cand = PTR_W'(idx);
            if (!any_vld && vld_in[cand]) begin
                any_vld = 1'b1;
                winner  = cand;
            end
        end
    end

    always_comb begin
        win_word = '0;
        for (int p = 0; p < NUM_PORTS; p++)
            if (winner == PTR_W'(p)) win_word = din[p*IN_WIDTH +: IN_WIDTH];
    end

    assign arb_ok  = (state_q == IDLE) ||
                     (rdy_downward && (cnt_q == CNT_LAST));
    assign capture = reset && arb_ok && any_vld;

    always_comb begin
        rdy_upward = '0;
        if (capture) rdy_upward[winner] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        sreg_d  = sreg_q;
        if (capture) begin
            state_d = SEND;
            grant_d = winner;
            cnt_d   = '0;
            sreg_d  = win_word;
            ptr_d   = (winner == PTR_LAST) ? '0 : winner + PTR_W'(1);
        end else if (state_q == SEND && rdy_downward) begin
            if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                sreg_d = sreg_q >> OUT_WIDTH;
                cnt_d  = cnt_q + CNT_W'(1);
            end
        end
        // A new kernel run restarts fairness from port 0; the word in flight continues.
        if (ap_start && !ap_start_dly_q) ptr_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            grant_q        <= '0;
            cnt_q          <= '0;
            sreg_q         <= '0;
            ap_start_dly_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            cnt_q          <= cnt_d;
            sreg_q         <= sreg_d;
            ap_start_dly_q <= ap_start;
        end
    end

    assign vld_out  = (state_q == SEND);
    assign dout     = vld_out ? sreg_q[OUT_WIDTH-1:0] : '0;
    assign last_out = vld_out && (cnt_q == CNT_LAST);
    assign src_id   = vld_out ? ID_WIDTH'(grant_q) : '0;
endmodule

// File: tb/tb_write_queue_arb.sv
// Bench for write_queue_arb: scoreboard of expected beats filled on upstream
// handshakes and drained on link acceptance, plus per-scenario directed checks.
module tb_write_queue_arb;
    localparam int NP  = 4;
    localparam int IW  = 512;
    localparam int OW  = 32;
    localparam int IDW = 2;
    localparam int MAX = IW / OW;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           last;
        logic [OW-1:0]  data;
    } beat_t;

    logic                  clk;
    logic                  reset;
    logic [NP-1:0][IW-1:0] din_a;
    logic [NP-1:0]         vld_in;
    logic [NP-1:0]         rdy_upward;
    logic [OW-1:0]         dout;
    logic                  vld_out;
    logic                  last_out;
    logic [IDW-1:0]        src_id;
    logic                  rdy_downward;
    logic                  ap_start;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_q[$];
    int    grant_log[$];
    beat_t prev_beat;
    bit    prev_stall = 1'b0;

    write_queue_arb #(.NUM_PORTS(NP), .IN_WIDTH(IW), .OUT_WIDTH(OW), .ID_WIDTH(IDW)) dut (
        .clk(clk), .reset(reset), .din(din_a), .vld_in(vld_in), .rdy_upward(rdy_upward),
        .dout(dout), .vld_out(vld_out), .last_out(last_out), .src_id(src_id),
        .rdy_downward(rdy_downward), .ap_start(ap_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: push a word's beats on upstream handshake, pop on link accept.
    always @(negedge clk) begin
        if (!reset) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_checks++;
                if (!vld_out || dout !== prev_beat.data || src_id !== prev_beat.id ||
                    last_out !== prev_beat.last) begin
                    n_fail++;
                    $display("FAIL hold: got vld=%0b d=%h id=%0d l=%0b want d=%h id=%0d l=%0b",
                             vld_out, dout, src_id, last_out, prev_beat.data, prev_beat.id, prev_beat.last);
                end
            end
            n_checks++;
            if ($countones(rdy_upward) > 1) begin
                n_fail++;
                $display("FAIL rdy_onehot: got %b want at most one bit", rdy_upward);
            end
            n_checks++;
            if (vld_out && rdy_upward != '0 && !(last_out && rdy_downward)) begin
                n_fail++;
                $display("FAIL rdy_in_send: got %b want 0 mid-word", rdy_upward);
            end
            for (int p = 0; p < NP; p++) begin
                if (vld_in[p] && rdy_upward[p]) begin
                    logic [IW-1:0] w;
                    w = din_a[p];
                    grant_log.push_back(p);
                    for (int k = 0; k < MAX; k++)
                        exp_q.push_back('{id: IDW'(p), last: (k == MAX-1), data: w[k*OW +: OW]});
                end
            end
            if (vld_out && rdy_downward) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got beat %h id=%0d want none", dout, src_id);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    if (e.data !== dout || e.id !== src_id || e.last !== last_out) begin
                        n_fail++;
                        $display("FAIL sb_beat: got d=%h id=%0d l=%0b want d=%h id=%0d l=%0b",
                                 dout, src_id, last_out, e.data, e.id, e.last);
                    end
                end
            end
            prev_stall = vld_out && !rdy_downward;
            prev_beat  = '{id: src_id, last: last_out, data: dout};
        end
    end

    task automatic cycle();
        @(posedge clk); #1;
    endtask

    task automatic set_word(input int p, input logic [31:0] base);
        for (int k = 0; k < MAX; k++) din_a[p][k*OW +: OW] = base + 32'(k);
    endtask

    // Drops each port's valid right after its handshake.
    task automatic run_drop(input int n);
        logic [NP-1:0] r;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            r = rdy_upward & vld_in;
            @(posedge clk); #1;
            vld_in = vld_in & ~r;
        end
    endtask

    task automatic drain(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            run_drop(1);
            if (exp_q.size() == 0 && !vld_out) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0; vld_in = '0; ap_start = 1'b0; rdy_downward = 1'b1;
        cycle(); cycle();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rdy_downward = 1'b1;
        for (int p = 0; p < NP; p++) set_word(p, 32'hA000_0000);
        vld_in = '1;
        cycle(); cycle();
        @(negedge clk);
        n_checks += 5;
        if (rdy_upward !== '0) begin n_fail++; $display("FAIL reset_rdy: got %b want 0", rdy_upward); end
        if (vld_out !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", vld_out); end
        if (last_out !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", last_out); end
        if (dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", dout); end
        if (src_id !== '0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", src_id); end
        vld_in = '0;
        cycle();
        reset = 1'b1;
        cycle();
        @(negedge clk);
        n_checks++;
        if (vld_out !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got vld %b want 0", vld_out); end
    endtask

    task automatic test_single();
        int rdy_cnt = 0, beats = 0, lasts = 0, rdy_cyc = -1, first_cyc = -1;
        bit ok;
        cycle();
        grant_log.delete();
        set_word(2, 32'h1000_0000);
        vld_in[2] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdy_upward[2]) begin rdy_cnt++; rdy_cyc = c; end
            if (vld_out && rdy_downward) begin
                if (first_cyc < 0) first_cyc = c;
                n_checks++;
                if (dout !== 32'h1000_0000 + 32'(beats) || src_id !== 2'd2 || last_out !== (beats == MAX-1)) begin
                    n_fail++;
                    $display("FAIL single_beat%0d: got d=%h id=%0d l=%0b want d=%h id=2 l=%0b",
                             beats, dout, src_id, last_out, 32'h1000_0000 + 32'(beats), beats == MAX-1);
                end
                if (last_out) lasts++;
                beats++;
            end
            @(posedge clk); #1;
            if (rdy_cnt > 0) vld_in[2] = 1'b0;
        end
        n_checks += 5;
        if (rdy_cnt != 1) begin n_fail++; $display("FAIL single_rdy_cycles: got %0d want 1", rdy_cnt); end
        if (beats != MAX) begin n_fail++; $display("FAIL single_beats: got %0d want %0d", beats, MAX); end
        if (lasts != 1) begin n_fail++; $display("FAIL single_lasts: got %0d want 1", lasts); end
        if (first_cyc != rdy_cyc + 1) begin n_fail++; $display("FAIL single_latency: got %0d want %0d", first_cyc, rdy_cyc + 1); end
        if (grant_log.size() != 1 || grant_log[0] != 2) begin n_fail++; $display("FAIL single_grant: got %p want 2", grant_log); end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL single_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        int exp_g[5] = '{0, 1, 2, 3, 0};
        int first = -1, busy = 0, seq = 0;
        logic [NP-1:0] r;
        bit ok;
        do_reset();
        grant_log.delete();
        for (int p = 0; p < NP; p++) set_word(p, 32'h3000_0000 | (32'(p) << 20));
        vld_in = '1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            r = rdy_upward;
            if (vld_out) begin
                if (first < 0) first = c;
                if (c < first + 64 && rdy_downward) busy++;
            end
            @(posedge clk); #1;
            for (int p = 0; p < NP; p++)
                if (r[p]) begin
                    seq++;
                    set_word(p, 32'h3000_0000 | (32'(p) << 20) | (32'(seq) << 8));
                end
        end
        vld_in = '0;
        n_checks += 2;
        if (busy != 64) begin n_fail++; $display("FAIL rr_throughput: got %0d beats want 64", busy); end
        if (grant_log.size() < 5) begin
            n_fail++; $display("FAIL rr_grants: got %0d grants want >=5", grant_log.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (grant_log[i] != exp_g[i]) begin
                    n_fail++; $display("FAIL rr_order%0d: got %0d want %0d", i, grant_log[i], exp_g[i]);
                end
            end
        end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rr_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        int acc = 0;
        logic [NP-1:0] r;
        bit ok;
        cycle();
        grant_log.delete();
        set_word(0, 32'h2000_0000);
        vld_in[0] = 1'b1;
        rdy_downward = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            r = rdy_upward & vld_in;
            if (vld_out) begin
                n_checks++;
                if (dout !== 32'h2000_0000 + 32'(acc) || last_out !== (acc == MAX-1)) begin
                    n_fail++;
                    $display("FAIL bp_beat%0d: got d=%h l=%0b want d=%h l=%0b",
                             acc, dout, last_out, 32'h2000_0000 + 32'(acc), acc == MAX-1);
                end
                if (rdy_downward) acc++;
            end
            @(posedge clk); #1;
            vld_in = vld_in & ~r;
            rdy_downward = ~rdy_downward;
            if (acc == MAX) break;
        end
        rdy_downward = 1'b1;
        n_checks += 2;
        if (acc != MAX) begin n_fail++; $display("FAIL bp_count: got %0d want %0d", acc, MAX); end
        if (grant_log.size() != 1 || grant_log[0] != 0) begin n_fail++; $display("FAIL bp_grant: got %p want 0", grant_log); end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL bp_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_ap_start();
        int exp_g[3] = '{1, 0, 3};
        bit ok;
        do_reset();
        grant_log.delete();
        set_word(1, 32'h4100_0000);
        vld_in[1] = 1'b1;
        for (int c = 0; c < 10 && vld_in[1]; c++) run_drop(1);
        set_word(0, 32'h4000_0000);
        set_word(3, 32'h4300_0000);
        vld_in[0] = 1'b1;
        vld_in[3] = 1'b1;
        ap_start = 1'b1;
        cycle();
        ap_start = 1'b0;
        run_drop(60);
        n_checks++;
        if (grant_log.size() != 3) begin
            n_fail++; $display("FAIL aps_grants: got %p want 1 0 3", grant_log);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (grant_log[i] != exp_g[i]) begin
                    n_fail++; $display("FAIL aps_order%0d: got %0d want %0d", i, grant_log[i], exp_g[i]);
                end
            end
        end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL aps_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_last_beat();
        bit found = 1'b0, ok;
        cycle();
        set_word(1, 32'h5100_0000);
        vld_in[1] = 1'b1;
        for (int c = 0; c < 10 && vld_in[1]; c++) run_drop(1);
        for (int c = 0; c < 40; c++) begin
            cycle();
            if (vld_out && last_out) begin found = 1'b1; break; end
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL lb_reach: got no last beat want one"); end
        set_word(3, 32'h5300_0000);
        vld_in[3] = 1'b1;
        @(negedge clk);
        n_checks += 2;
        if (rdy_upward !== 4'b1000) begin n_fail++; $display("FAIL lb_rdy: got %b want 1000", rdy_upward); end
        if (dout !== 32'h5100_000F) begin n_fail++; $display("FAIL lb_prev: got %h want 5100000f", dout); end
        cycle();
        vld_in[3] = 1'b0;
        @(negedge clk);
        n_checks += 3;
        if (vld_out !== 1'b1) begin n_fail++; $display("FAIL lb_vld: got %b want 1", vld_out); end
        if (src_id !== 2'd3) begin n_fail++; $display("FAIL lb_id: got %0d want 3", src_id); end
        if (dout !== 32'h5300_0000) begin n_fail++; $display("FAIL lb_beat0: got %h want 53000000", dout); end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL lb_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midword();
        bit found = 1'b0, ok;
        do_reset();
        set_word(0, 32'h6000_0000);
        vld_in[0] = 1'b1;
        for (int c = 0; c < 10 && vld_in[0]; c++) run_drop(1);
        for (int c = 0; c < 40; c++) begin
            if (vld_out && dout === 32'h6000_0007) begin found = 1'b1; break; end
            cycle();
        end
        n_checks++;
        if (!found) begin n_fail++; $display("FAIL rm_reach: got no beat 7 want one"); end
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        @(negedge clk);
        n_checks += 3;
        if (vld_out !== 1'b0) begin n_fail++; $display("FAIL rm_vld: got %b want 0", vld_out); end
        if (rdy_upward !== '0) begin n_fail++; $display("FAIL rm_rdy: got %b want 0", rdy_upward); end
        if (src_id !== '0) begin n_fail++; $display("FAIL rm_id: got %0d want 0", src_id); end
        cycle();
        grant_log.delete();
        set_word(0, 32'h6A00_0000);
        set_word(3, 32'h6300_0000);
        vld_in = 4'b1001;
        @(negedge clk);
        n_checks++;
        if (rdy_upward !== 4'b0001) begin n_fail++; $display("FAIL rm_ptr: got %b want 0001", rdy_upward); end
        cycle();
        vld_in[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (dout !== 32'h6A00_0000 || src_id !== 2'd0 || vld_out !== 1'b1) begin
            n_fail++; $display("FAIL rm_restart: got d=%h id=%0d v=%b want d=6a000000 id=0 v=1", dout, src_id, vld_out);
        end
        run_drop(40);
        n_checks++;
        if (grant_log.size() != 2 || grant_log[0] != 0 || grant_log[1] != 3) begin
            n_fail++; $display("FAIL rm_grants: got %p want 0 3", grant_log);
        end
        drain(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL rm_drain: got %0d pending want 0", exp_q.size()); end
    endtask

    initial begin
        reset = 1'b0; vld_in = '0; din_a = '0; rdy_downward = 1'b1; ap_start = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_ap_start();
        test_last_beat();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/write_queue_arb.md
Name: write_queue_arb

Overview:
Round-robin arbiter and serializer that shares one narrow output stream among NUM_PORTS wide producers. A whole IN_WIDTH word is granted at a time and emitted as MAX = IN_WIDTH/OUT_WIDTH beats, LSB slice first, so words from different ports never interleave. It sits between several kernel output ports and a single OUT_WIDTH link, with a source-id sideband for downstream routing. It replaces per-port width downconverters when the link is shared.

Parameters:
NUM_PORTS, 4, number of wide producers (2..16)
IN_WIDTH, 512, width of each producer word; integer multiple of OUT_WIDTH
OUT_WIDTH, 32, link beat width
ID_WIDTH, 2, width of src_id; must satisfy 2^ID_WIDTH >= NUM_PORTS
(derived) MAX = IN_WIDTH/OUT_WIDTH, must be >= 2

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-low reset (asserted when 0)
din  in  NUM_PORTS*IN_WIDTH  port p word at bits [p*IN_WIDTH +: IN_WIDTH]
vld_in  in  NUM_PORTS  per-port valid
rdy_upward  out  NUM_PORTS  per-port ready; at most one bit set
dout  out  OUT_WIDTH  current beat
vld_out  out  1  beat valid
last_out  out  1  final beat of a word
src_id  out  ID_WIDTH  port index of the word being emitted
rdy_downward  in  1  link ready
ap_start  in  1  kernel start; rising edge resets arbitration pointer

Behaviour:
- Handshake: transfer on a port when vld_in[p] && rdy_upward[p]; on the link when vld_out && rdy_downward. Once vld_out rises, dout, last_out and src_id hold until the beat is accepted.
- Registers: state (IDLE/SEND), ptr (rr pointer), grant, cnt (0..MAX-1), sreg (IN_WIDTH shift register), ap_start_d.
- Arbitration function: winner = first p with vld_in[p]=1, searching ptr, ptr+1, ... wrapping mod NUM_PORTS. "arb_ok" is true in IDLE, and in SEND on the cycle the last beat is accepted.
- rdy_upward: combinational, one-hot at winner when arb_ok && any vld_in; otherwise all 0. Ready may depend on valid.
- IDLE: vld_out=0, last_out=0, dout=0. On a winner, capture sreg<=din[winner], grant<=winner, cnt<=0, ptr<=(winner+1) mod NUM_PORTS, go to SEND. With no vld_in, stay in IDLE.
- SEND: vld_out=1, dout=sreg[OUT_WIDTH-1:0], src_id=grant, last_out=(cnt==MAX-1), all rdy_upward=0 except on the last-beat-accept cycle.
  - On an accepted non-last beat: sreg shifts right by OUT_WIDTH (zero fill) and cnt increments.
  - On an accepted last beat with a new winner: capture it as in IDLE and stay in SEND. Zero bubble cycles between words.
  - On an accepted last beat with no winner: go to IDLE and set cnt<=0.
  - When rdy_downward=0: all SEND state holds.
- Latency: an accepted word produces its first beat on the next cycle. Sustained throughput is one beat per cycle. A word occupies exactly MAX link beats.
- src_id: equals grant in SEND and is 0 in IDLE. Width is zero-extended from the port index.
- ap_start: ap_start_d registers ap_start. A rising edge (ap_start && !ap_start_d) forces ptr<=0 on that cycle, taking priority over the ptr update from a capture. The word in flight is not aborted.
- Fairness: a continuously valid port waits at most NUM_PORTS-1 words between grants.
- Reset (reset==0 at a clk edge): state=IDLE, ptr=0, grant=0, cnt=0, sreg=0, ap_start_d=0. Outputs then read vld_out=0, last_out=0, dout=0, src_id=0, rdy_upward=0 while reset is held. Mid-word reset discards the remaining beats with no partial flush. rdy_upward is forced to 0 while reset==0.
- Out of scope: vld_in[p] dropping without a transfer; any behaviour is acceptable.

Test Plan:
- Single word: port 2 sends din word with beat k = 32'h1000_0000+k, then vld_in drops. Required: 16 beats 32'h1000_0000..32'h1000_000F, src_id=2, last_out only on beat 15, rdy_upward[2] high for exactly 1 cycle.
- Round-robin: all 4 ports valid continuously from reset, rdy_downward=1. Required: grant order 0,1,2,3,0,...; 64 beats in 64 cycles after the first beat; no idle cycles between words.
- Backpressure: port 0 word, rdy_downward toggles 1,0,1,0. Required: each beat is held unchanged while rdy_downward=0; 16 accepted beats in order; rdy_upward stays 0 during SEND until the last accepted beat.
- ap_start pointer reset: after a grant to port 1 (ptr=2), pulse ap_start with ports 0 and 3 valid. Required: the current word completes, then port 0 is granted before port 3.
- Simultaneous arrival at the last beat: port 1 word in SEND at cnt=15, port 3 asserts vld_in on the same cycle the beat is accepted. Required: rdy_upward[3]=1 that cycle; next cycle vld_out=1, src_id=3, beat 0 of the port 3 word.
- Reset mid-word: reset=0 for 1 cycle at cnt=7. Required: the next cycle shows vld_out=0, rdy_upward=0 and src_id=0; a later word restarts at beat 0 with ptr=0.
